// File: rtl/usart_pkg.sv
// Shared USART definitions: receive state encoding, controller command set,
// and default timing parameters.
package usart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 138;
    localparam int DEFAULT_SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_SET_CTRL,
        CMD_SET_DATA,
        CMD_GET_DATA,
        CMD_GET_STATUS
    } usart_cmd_t;

    // Cycle index inside the start bit at which the line is re-checked
    // (mid-bit), so every later sample lands near a bit centre.
    function automatic int half_bit_last(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/usart_rx_if.sv
// Byte hand-off between the receive stage and the USART controller.
interface usart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_error;
    logic       overrun;
    logic       clear_errors;

    // master: the receiver producing bytes; slave: the consuming controller
    modport master (
        output rx_data, rx_valid, framing_error, overrun,
        input  rx_ready, clear_errors
    );
    modport slave (
        input  rx_data, rx_valid, framing_error, overrun,
        output rx_ready, clear_errors
    );
endinterface

// File: rtl/usart_sync.sv
// N-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module usart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // shift the raw input through the synchronizer chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/usart_rx.sv
// USART receive stage: synchronizes rx_pin, deframes 8N1 characters and
// hands each byte to the controller through a one-byte holding register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX_IDLE  | line idle, waiting for a low level (start bit candidate)
// RX_START | counting to mid start bit to reject short glitches
// RX_DATA  | sampling 8 data bits LSB-first at bit centres
// RX_STOP  | sampling the stop bit; good stop -> delivery
// RX_BREAK | stop bit was low; wait for the line to return high
module usart_rx
    import usart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_pin,
    usart_rx_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(half_bit_last(CLKS_PER_BIT));

    logic          rx_s;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          deliver;
    logic          ferr_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ovr_q;
    logic          drop;

    usart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_pin),
        .q       (rx_s)
    );

    // frame deframing FSM; deliver and framing_error are registered pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            deliver <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            deliver <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            bit_idx <= '0;
                            state   <= RX_DATA;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            deliver <= 1'b1;
                            state   <= RX_IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= RX_IDLE;
                end
                default: begin
                    state <= RX_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // a delivered byte is dropped only if the holding register stays full
    assign drop = deliver && valid_q && !bus.rx_ready;

    // holding register and sticky overrun flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (deliver && !drop) begin
                data_q  <= shift;
                valid_q <= 1'b1;
            end else if (valid_q && bus.rx_ready && !deliver) begin
                valid_q <= 1'b0;
            end
            if (drop) begin
                ovr_q <= 1'b1;
            end else if (bus.clear_errors) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.overrun       = ovr_q;

endmodule
